sprite_bus_arbiter: RTL
=======================

// Module: sprite_bus_arbiter
// PURPOSE
//   Shares the single-port sprite attribute RAM between the stack CPU's IO bus and the
//   sprite video engine. CPU writes are posted into a small FIFO and drained in video idle
//   cycles; video reads have priority, but a starvation guard bounds CPU write latency.
//   It also answers CPU IO reads with status (FIFO level, overflow, frame counter, vblank).
// PARAMETERS
//   DATA_WIDTH   16  CPU word / sprite RAM data width
//   SPR_AW       8   sprite RAM address width
//   FIFO_DEPTH   4   posted-write FIFO entries (power of 2)
//   MAX_WAIT     15  max cycles a non-empty FIFO may be blocked by video before a forced drain
// PORTS
//   clock        in   1           system clock, all state on rising edge
//   reset        in   1           asynchronous, active-high
//   io_addr      in   DATA_WIDTH  CPU IO address (combinational from CPU)
//   io_write     in   1           CPU IO write strobe, one cycle per store
//   io_wr_data   in   DATA_WIDTH  CPU IO write data
//   io_rd_data   out  DATA_WIDTH  CPU IO read data, combinational from io_addr
//   vid_req      in   1           video read request; held until vid_ack
//   vid_addr     in   SPR_AW      video read address
//   vid_ack      out  1           registered; high in the cycle vid_rd_data is valid
//   vid_rd_data  out  DATA_WIDTH  = spr_rd_data (pass-through)
//   vblank       in   1           vertical blank from video timing (same clock domain)
//   spr_addr     out  SPR_AW      sprite RAM address (combinational)
//   spr_we       out  1           sprite RAM write enable (combinational)
//   spr_wr_data  out  DATA_WIDTH  sprite RAM write data (combinational)
//   spr_rd_data  in   DATA_WIDTH  sprite RAM read data, 1-cycle registered latency
// BEHAVIOUR
//   Reset: FIFO empty, level=0, ovf=0, frame_cnt=0, wait_cnt=0, vid_ack=0, vblank_q=0.
//   Decode: sprite window = io_addr[15:14]==2'b01, RAM addr = io_addr[SPR_AW-1:0].
//     Status regs: 16'h8000 STATUS {ovf,12'b0,level[2:0]}; 16'h8001 frame_cnt;
//     16'h8002 {15'b0,vblank}; any other address reads 0. Window reads also return 0.
//   Push: io_write in window -> enqueue {addr,data}. If FIFO full and no pop this cycle,
//     drop the write and set ovf (sticky). If full and a pop occurs same cycle, accept.
//   ovf clear: io_write to 16'h8000 clears ovf; a same-cycle overflow wins (ovf stays 1).
//   Grant per cycle (combinational), one of: VID, CPU, IDLE:
//     CPU if level!=0 and (vid_req==0 or wait_cnt==MAX_WAIT); else VID if vid_req; else IDLE.
//     VID : spr_addr=vid_addr, spr_we=0; vid_ack<=1 next cycle.
//     CPU : spr_addr/spr_wr_data = FIFO head, spr_we=1, pop; vid_ack<=0 next cycle.
//     IDLE: spr_we=0, spr_addr=vid_addr; vid_ack<=0.
//   Video latency: request granted at cycle N -> vid_ack=1, data valid at N+1. Back-to-back
//     requests are allowed; engine changes vid_addr only after vid_ack.
//   wait_cnt: increments (saturating at MAX_WAIT) while level!=0 and grant==VID; cleared on
//     any CPU grant or when level==0.
//   Write ordering: FIFO is strict FIFO; a video read of an address with a pending write
//     returns the old value (no forwarding).
//   frame_cnt: +1 on vblank rising edge (vblank & ~vblank_q), wraps 16'hFFFF -> 0.
//   Reset asserted mid-operation: pending FIFO writes discarded, no spr_we after reset.
// TESTING
//   1 Reset, vid_req=0; CPU writes 16'h4005<-16'h1234 -> next cycle spr_we=1, addr 05,
//     data 1234; STATUS reads level=0 after drain.
//   2 vid_req=1 continuously, CPU writes 3 words -> drains blocked 15 cycles, then one
//     forced CPU slot (vid_ack low the following cycle), wait_cnt restarts.
//   3 vid_req held, 5 writes in 5 cycles with no drain -> 4 queued, 5th dropped, STATUS=16'h8004;
//     write 16'h8000 -> ovf=0; queued data appears in order 1..4 at RAM.
//   4 vid_req at cycle N with vid_addr=8'h10, RAM holds 16'hBEEF -> vid_ack=1 and
//     vid_rd_data=16'hBEEF at N+1; back-to-back addrs 10,11 -> acks at N+1,N+2.
//   5 Toggle vblank 3 times -> 16'h8001 reads 3; preload 16'hFFFF, one edge -> 0.
//   6 Full FIFO + simultaneous pop and push -> push accepted, ovf stays 0; async reset
//     mid-drain -> spr_we low immediately, level=0, vid_ack=0.

Source files
------------

// File: rtl/sprite_bus_arbiter.sv
// Sprite attribute RAM arbiter: posted CPU writes drain around video reads, with a
// starvation guard on the write FIFO and a small CPU-visible status block.
module sprite_bus_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int SPR_AW     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] io_addr,
    input  logic                  io_write,
    input  logic [DATA_WIDTH-1:0] io_wr_data,
    output logic [DATA_WIDTH-1:0] io_rd_data,
    input  logic                  vid_req,
    input  logic [SPR_AW-1:0]     vid_addr,
    output logic                  vid_ack,
    output logic [DATA_WIDTH-1:0] vid_rd_data,
    input  logic                  vblank,
    output logic [SPR_AW-1:0]     spr_addr,
    output logic                  spr_we,
    output logic [DATA_WIDTH-1:0] spr_wr_data,
    input  logic [DATA_WIDTH-1:0] spr_rd_data
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [LVL_W-1:0]      LVL_FULL    = LVL_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0]     WAIT_LIMIT  = WAIT_W'(MAX_WAIT);
    localparam logic [DATA_WIDTH-1:0] ADDR_STATUS = DATA_WIDTH'(16'h8000);
    localparam logic [DATA_WIDTH-1:0] ADDR_FRAME  = DATA_WIDTH'(16'h8001);
    localparam logic [DATA_WIDTH-1:0] ADDR_VBLANK = DATA_WIDTH'(16'h8002);

    typedef enum logic [1:0] {
        GRANT_IDLE,
        GRANT_VID,
        GRANT_CPU
    } grant_t;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == WAIT_LIMIT) ? v : v + 1'b1;
    endfunction

    logic [SPR_AW-1:0]     fifo_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  ovf;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [DATA_WIDTH-1:0] frame_cnt;
    logic                  vblank_q;
    logic                  vld_p1;

    logic                  in_window;
    logic                  push_req;
    logic                  fifo_full;
    logic                  fifo_empty;
    grant_t                grant;
    logic                  pop;
    logic                  push;
    logic                  overflow;
    logic                  ovf_clr;
    logic                  frame_load;
    logic                  vblank_rise;
    logic [DATA_WIDTH-1:0] status_word;

    assign in_window   = (io_addr[DATA_WIDTH-1 -: 2] == 2'b01);
    assign push_req    = io_write && in_window;
    assign fifo_full   = (level == LVL_FULL);
    assign fifo_empty  = (level == '0);
    assign ovf_clr     = io_write && (io_addr == ADDR_STATUS);
    assign frame_load  = io_write && (io_addr == ADDR_FRAME);
    assign vblank_rise = vblank && !vblank_q;

    // Video wins unless the FIFO has waited MAX_WAIT cycles behind it.
    always_comb begin
        grant = GRANT_IDLE;
        if (!fifo_empty && (!vid_req || wait_cnt == WAIT_LIMIT)) begin
            grant = GRANT_CPU;
        end else if (vid_req) begin
            grant = GRANT_VID;
        end
    end

    assign pop      = (grant == GRANT_CPU);
    assign push     = push_req && (!fifo_full || pop);
    assign overflow = push_req && fifo_full && !pop;

    always_comb begin
        spr_addr    = vid_addr;
        spr_we      = 1'b0;
        spr_wr_data = fifo_data[rd_ptr];
        if (grant == GRANT_CPU) begin
            spr_addr = fifo_addr[rd_ptr];
            spr_we   = 1'b1;
        end
    end

    assign vid_rd_data = spr_rd_data;
    assign vid_ack     = vld_p1;

    always_comb begin
        status_word                  = '0;
        status_word[DATA_WIDTH-1]    = ovf;
        status_word[LVL_W-1:0]       = level;
    end

    always_comb begin
        io_rd_data = '0;
        if (io_addr == ADDR_STATUS) begin
            io_rd_data = status_word;
        end else if (io_addr == ADDR_FRAME) begin
            io_rd_data = frame_cnt;
        end else if (io_addr == ADDR_VBLANK) begin
            io_rd_data[0] = vblank;
        end
    end

    // FIFO storage carries data only; occupancy is tracked by the pointers and level.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= io_addr[SPR_AW-1:0];
            fifo_data[wr_ptr] <= io_wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // A same-cycle overflow keeps the sticky flag set even while it is being cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (overflow) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (fifo_empty || grant == GRANT_CPU) begin
            wait_cnt <= '0;
        end else if (grant == GRANT_VID) begin
            wait_cnt <= sat_inc(wait_cnt);
        end
    end

    // Stage p1: acknowledge lines up with the RAM's registered read data.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= (grant == GRANT_VID);
        end
    end

    // A CPU store to the frame counter address preloads it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vblank_q  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vblank_q <= vblank;
            if (frame_load) begin
                frame_cnt <= io_wr_data;
            end else if (vblank_rise) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

endmodule
